// File: rtl/intra16_pred_ctrl_pkg.sv
// Shared definitions for the Intra16x16 luma predictor sequencer: load-strobe
// codes, residual handshake state codes, prediction mode codes, neighbour group
// indices and the load-list builder used when a macroblock starts.
package intra16_pred_ctrl_pkg;

  // Neighbour groups: 0-3 left column (4 rows each), 4-7 top row, 8 corner.
  localparam int         NUM_GRP    = 9;
  localparam logic [3:0] GRP_LEFT0  = 4'd0;
  localparam logic [3:0] GRP_TOP0   = 4'd4;
  localparam logic [3:0] GRP_CORNER = 4'd8;

  typedef enum logic [1:0] {
    Intra16x16_V     = 2'd0,
    Intra16x16_H     = 2'd1,
    Intra16x16_DC    = 2'd2,
    Intra16x16_Plane = 2'd3
  } i16_mode_e;

  // Predictor load strobe codes; a read of group g lands as code g+1.
  typedef enum logic [3:0] {
    intra16r_rst = 4'd0,
    intra16r_v0  = 4'd1,
    intra16r_v1  = 4'd2,
    intra16r_v2  = 4'd3,
    intra16r_v3  = 4'd4,
    intra16r_h0  = 4'd5,
    intra16r_h1  = 4'd6,
    intra16r_h2  = 4'd7,
    intra16r_h3  = 4'd8,
    intra16r_pl  = 4'd9
  } state16_e;

  typedef enum logic [2:0] {
    RES_IDLE = 3'd0,
    RES_PRED = 3'd1,
    RES_WAIT = 3'd2
  } res_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_PRED,
    ST_OUT,
    ST_DONE
  } ctrl_state_e;

  // One bit per neighbour group that must be loaded for this mode and
  // availability. Plane always needs the full neighbourhood.
  function automatic logic [NUM_GRP-1:0] load_mask(input logic [1:0] mode,
                                                   input logic       avail_left,
                                                   input logic       avail_top);
    logic [NUM_GRP-1:0] m;
    m = '0;
    case (mode)
      Intra16x16_V: begin
        if (avail_top) m[GRP_TOP0 +: 4] = 4'hF;
      end
      Intra16x16_H: begin
        if (avail_left) m[GRP_LEFT0 +: 4] = 4'hF;
      end
      Intra16x16_DC: begin
        if (avail_left) m[GRP_LEFT0 +: 4] = 4'hF;
        if (avail_top)  m[GRP_TOP0 +: 4]  = 4'hF;
      end
      default: begin
        m[GRP_LEFT0 +: 4] = 4'hF;
        m[GRP_TOP0 +: 4]  = 4'hF;
        m[GRP_CORNER]     = 1'b1;
      end
    endcase
    return m;
  endfunction

  function automatic logic [3:0] grp_code(input logic [3:0] grp);
    return grp + 4'd1;
  endfunction

endpackage

// File: rtl/intra16_pred_ctrl_nb_fetch.sv
// Neighbour fetch: builds the group load list on load_i, issues one
// neighbour-buffer read per cycle (lowest group first = left, top, corner) and
// delays each read by NB_LAT cycles to form the predictor load strobe state16_o.
// Latency: first read one cycle after load_i; strobe NB_LAT cycles after read.
// No backpressure: the buffer accepts a read every cycle; flush_i drops all.
// Ports: clk/reset_n; flush_i abort; load_i start with mode_i/avail_*_i;
//   empty_o list empty for current inputs; last_o final read issuing now;
//   nb_rd_en_o/nb_rd_grp_o read strobe/group; state16_o load strobe code.
module intra16_nb_fetch
  import intra16_pred_ctrl_pkg::*;
#(
  parameter int NB_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush_i,
  input  logic       load_i,
  input  logic [1:0] mode_i,
  input  logic       avail_left_i,
  input  logic       avail_top_i,
  output logic       empty_o,
  output logic       last_o,
  output logic       nb_rd_en_o,
  output logic [3:0] nb_rd_grp_o,
  output logic [3:0] state16_o
);

  logic [NUM_GRP-1:0] new_mask;
  logic [NUM_GRP-1:0] src_mask;
  logic [NUM_GRP-1:0] mask_q;
  logic               rd_en_q;
  logic [3:0]         grp_q;
  logic [3:0]         pick;
  logic               pick_vld;
  logic [3:0]         dly_q [NB_LAT];

  assign new_mask = load_mask(mode_i, avail_left_i, avail_top_i);
  // On the load cycle the list comes straight from the inputs so the first
  // read is issued on the very next cycle.
  assign src_mask = load_i ? new_mask : mask_q;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_GRP - 1; i >= 0; i--) begin
      if (src_mask[i]) begin
        pick     = 4'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      rd_en_q <= 1'b0;
      grp_q   <= '0;
      for (int k = 0; k < NB_LAT; k++) dly_q[k] <= intra16r_rst;
    end else if (flush_i) begin
      mask_q  <= '0;
      rd_en_q <= 1'b0;
      grp_q   <= '0;
      for (int k = 0; k < NB_LAT; k++) dly_q[k] <= intra16r_rst;
    end else begin
      rd_en_q  <= pick_vld;
      grp_q    <= pick_vld ? pick : 4'd0;
      mask_q   <= src_mask & ~(9'd1 << pick);
      dly_q[0] <= rd_en_q ? grp_code(grp_q) : intra16r_rst;
      for (int k = 1; k < NB_LAT; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  assign empty_o     = (new_mask == '0);
  assign last_o      = rd_en_q && (mask_q == '0);
  assign nb_rd_en_o  = rd_en_q;
  assign nb_rd_grp_o = grp_q;
  assign state16_o   = dly_q[NB_LAT-1];

endmodule

// File: rtl/intra16_pred_ctrl.sv
// Intra16x16 luma predictor sequencer: one macroblock per mb_start; loads the
// needed neighbours, then steps the 16 4x4 blocks through PRED/OUT.
// Latency: first blk_valid loads+NB_LAT+2 cycles after mb_start (2 if no loads).
// Backpressure: blk_valid holds until blk_ack; abort flushes to IDLE next cycle.
// Ports: clk/reset_n; mb_start, pred_mode, avail_left/top sampled on start;
//   abort flush; blk_ack consumer accept; nb_rd_en/nb_rd_grp buffer read;
//   state16 load strobe; intra16_pred_num block index; residual_intra16_state
//   handshake phase; blk_valid block ready; mb_done end pulse; busy not IDLE.
module intra16_pred_ctrl
  import intra16_pred_ctrl_pkg::*;
#(
  parameter int NB_LAT   = 1,
  parameter int BLK_LAST = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mb_start,
  input  logic [1:0] pred_mode,
  input  logic       avail_left,
  input  logic       avail_top,
  input  logic       abort,
  input  logic       blk_ack,
  output logic       nb_rd_en,
  output logic [3:0] nb_rd_grp,
  output logic [3:0] state16,
  output logic [4:0] intra16_pred_num,
  output logic [2:0] residual_intra16_state,
  output logic       blk_valid,
  output logic       mb_done,
  output logic       busy
);

  ctrl_state_e state_q;
  logic [4:0]  num_q;
  logic [7:0]  drain_q;
  logic        blk_valid_q;
  logic        mb_done_q;
  logic        busy_q;
  logic [2:0]  res_q;
  logic        load;
  logic        list_empty;
  logic        fetch_last;

  // mb_start counts only in IDLE; abort wins over a coincident start.
  assign load = (state_q == ST_IDLE) && mb_start && !abort;

  intra16_nb_fetch #(
    .NB_LAT(NB_LAT)
  ) u_fetch (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (abort),
    .load_i      (load),
    .mode_i      (pred_mode),
    .avail_left_i(avail_left),
    .avail_top_i (avail_top),
    .empty_o     (list_empty),
    .last_o      (fetch_last),
    .nb_rd_en_o  (nb_rd_en),
    .nb_rd_grp_o (nb_rd_grp),
    .state16_o   (state16)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      drain_q     <= '0;
      blk_valid_q <= 1'b0;
      mb_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= RES_IDLE;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      drain_q     <= '0;
      blk_valid_q <= 1'b0;
      mb_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= RES_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            busy_q <= 1'b1;
            // Nothing to load (e.g. DC without neighbours): predict at once.
            if (list_empty) begin
              state_q <= ST_PRED;
              res_q   <= RES_PRED;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (fetch_last) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end
        end
        ST_DRAIN: begin
          // Covers the buffer latency so the final strobe lands before PRED.
          if (drain_q == 8'(NB_LAT - 1)) begin
            state_q <= ST_PRED;
            res_q   <= RES_PRED;
          end else begin
            drain_q <= drain_q + 8'd1;
          end
        end
        ST_PRED: begin
          state_q     <= ST_OUT;
          res_q       <= RES_WAIT;
          blk_valid_q <= 1'b1;
        end
        ST_OUT: begin
          if (blk_ack) begin
            blk_valid_q <= 1'b0;
            if (num_q == 5'(BLK_LAST)) begin
              state_q   <= ST_DONE;
              res_q     <= RES_IDLE;
              mb_done_q <= 1'b1;
              num_q     <= '0;
            end else begin
              state_q <= ST_PRED;
              res_q   <= RES_PRED;
              num_q   <= num_q + 5'd1;
            end
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          mb_done_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign intra16_pred_num       = num_q;
  assign residual_intra16_state = res_q;
  assign blk_valid              = blk_valid_q;
  assign mb_done                = mb_done_q;
  assign busy                   = busy_q;

endmodule

// File: tb/tb_intra16_pred_ctrl.sv
`timescale 1ns/1ps
module tb_intra16_pred_ctrl;

  localparam int NB_LAT   = 1;
  localparam int BLK_LAST = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mb_start;
  logic [1:0] pred_mode;
  logic       avail_left;
  logic       avail_top;
  logic       abort;
  logic       blk_ack;
  logic       nb_rd_en;
  logic [3:0] nb_rd_grp;
  logic [3:0] state16;
  logic [4:0] intra16_pred_num;
  logic [2:0] residual_intra16_state;
  logic       blk_valid;
  logic       mb_done;
  logic       busy;

  intra16_pred_ctrl #(.NB_LAT(NB_LAT), .BLK_LAST(BLK_LAST)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .mb_start              (mb_start),
    .pred_mode             (pred_mode),
    .avail_left            (avail_left),
    .avail_top             (avail_top),
    .abort                 (abort),
    .blk_ack               (blk_ack),
    .nb_rd_en              (nb_rd_en),
    .nb_rd_grp             (nb_rd_grp),
    .state16               (state16),
    .intra16_pred_num      (intra16_pred_num),
    .residual_intra16_state(residual_intra16_state),
    .blk_valid             (blk_valid),
    .mb_done               (mb_done),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; } ev_t;
  ev_t rd_q[$];
  ev_t s16_q[$];
  ev_t blk_q[$];
  ev_t done_q[$];
  ev_t idle_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en    = 1'b0;
  bit exp_valid = 1'b0;
  int exp_num   = 0;
  int grp_list[$];
  ev_t mon_e;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
  endtask

  task automatic flag(input string name, input int got);
    n_checks++;
    $display("FAIL %s at cycle %0d: value %0d with nothing expected", name, cyc, got);
  endtask

  function automatic int outs_word();
    return int'({busy, blk_valid, nb_rd_en, mb_done, nb_rd_grp, state16,
                 intra16_pred_num, residual_intra16_state});
  endfunction

  task automatic push_ev(input int which, input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    case (which)
      0:       rd_q.push_back(e);
      1:       s16_q.push_back(e);
      2:       blk_q.push_back(e);
      3:       done_q.push_back(e);
      default: idle_q.push_back(e);
    endcase
  endtask

  // Reference load list: neighbour groups in load order (left, top, corner).
  task automatic build_list(input int mode, input bit al, input bit at);
    grp_list.delete();
    if (mode == 3) begin
      for (int g = 0; g < 9; g++) grp_list.push_back(g);
    end else begin
      if ((mode == 1 || mode == 2) && al) for (int g = 0; g < 4; g++) grp_list.push_back(g);
      if ((mode == 0 || mode == 2) && at) for (int g = 4; g < 8; g++) grp_list.push_back(g);
    end
  endtask

  // Monitor: compares every DUT presentation against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin mon_e = rd_q.pop_front(); chk("rd_missing", -1, mon_e.val); end
      if (s16_q.size() > 0 && s16_q[0].cyc < cyc) begin mon_e = s16_q.pop_front(); chk("s16_missing", -1, mon_e.val); end
      if (blk_q.size() > 0 && blk_q[0].cyc < cyc) begin mon_e = blk_q.pop_front(); chk("blk_missing", -1, mon_e.val); end
      if (done_q.size() > 0 && done_q[0].cyc < cyc) begin mon_e = done_q.pop_front(); chk("done_missing", 0, 1); end
      if (idle_q.size() > 0 && idle_q[0].cyc < cyc) begin mon_e = idle_q.pop_front(); chk("idle_missed", 0, 1); end

      if (nb_rd_en) begin
        if (rd_q.size() == 0) flag("rd_unexpected", nb_rd_grp);
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_cycle", cyc, mon_e.cyc);
          chk("rd_grp", nb_rd_grp, mon_e.val);
          chk("busy_fetch", busy, 1);
        end
      end
      if (state16 != 4'd0) begin
        if (s16_q.size() == 0) flag("state16_unexpected", state16);
        else begin
          mon_e = s16_q.pop_front();
          chk("state16_cycle", cyc, mon_e.cyc);
          chk("state16_code", state16, mon_e.val);
        end
      end
      if (blk_q.size() > 0 && blk_q[0].cyc == cyc + 1) begin
        chk("pred_state", residual_intra16_state, 1);
        chk("pred_valid_low", blk_valid, 0);
      end
      if (blk_valid && !exp_valid) begin
        if (blk_q.size() == 0) flag("blk_valid_unexpected", intra16_pred_num);
        else begin
          mon_e = blk_q.pop_front();
          chk("blk_cycle", cyc, mon_e.cyc);
          exp_valid = 1'b1;
          exp_num   = mon_e.val;
        end
      end
      if (exp_valid) begin
        chk("blk_valid_held", blk_valid, 1);
        chk("blk_num", intra16_pred_num, exp_num);
        chk("out_state", residual_intra16_state, 2);
        chk("busy_out", busy, 1);
        if (!blk_valid) exp_valid = 1'b0;
        else if (blk_ack) exp_valid = 1'b0;
      end
      if (mb_done) begin
        if (done_q.size() == 0) flag("mb_done_unexpected", 1);
        else begin
          mon_e = done_q.pop_front();
          chk("mb_done_cycle", cyc, mon_e.cyc);
        end
      end
      if (idle_q.size() > 0 && idle_q[0].cyc == cyc) begin
        mon_e = idle_q.pop_front();
        chk("idle_outputs", outs_word(), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    rd_q.delete(); s16_q.delete(); blk_q.delete(); done_q.delete(); idle_q.delete();
    exp_valid = 1'b0;
  endtask

  // One macroblock. ack_pol: 0 immediate acks, 1 random delays and extra acks.
  // abort_grp >= 0 aborts in the cycle that reads that list entry.
  task automatic run_mb(input int mode, input bit al, input bit at, input int ack_pol,
                        input int hold_blk, input int hold_len, input int abort_grp,
                        input bit start_in_done);
    int s, n, a, first, d, t;
    bit extra;
    build_list(mode, al, at);
    n = grp_list.size();
    s = cyc;
    a = (abort_grp >= 0) ? s + 1 + abort_grp : 32'h3fff_ffff;
    mb_start   = 1'b1;
    pred_mode  = 2'(mode);
    avail_left = al;
    avail_top  = at;
    for (int i = 0; i < n; i++) begin
      if (s + 1 + i <= a) push_ev(0, s + 1 + i, grp_list[i]);
      if (s + 2 + i <= a) push_ev(1, s + 2 + i, grp_list[i] + 1);
    end
    first = (n > 0) ? s + n + NB_LAT + 2 : s + 2;
    if (abort_grp < 0) push_ev(2, first, 0);
    step();
    mb_start   = 1'b0;
    pred_mode  = 2'($urandom_range(0, 3));
    avail_left = 1'($urandom_range(0, 1));
    avail_top  = 1'($urandom_range(0, 1));
    step();
    mb_start = 1'b1;  // start while busy must be ignored
    step();
    mb_start = 1'b0;
    if (abort_grp >= 0) begin
      while (cyc < a) step();
      abort = 1'b1;
      push_ev(4, a + 1, 0);
      step();
      abort = 1'b0;
      step();
      step();
      return;
    end
    for (int b = 0; b <= BLK_LAST; b++) begin
      t = 0;
      while (!blk_valid && t < 64) begin step(); t++; end
      if (!blk_valid) begin
        flag("blk_valid_timeout", b);
        abort = 1'b1;
        step();
        abort = 1'b0;
        clear_sb();
        step();
        return;
      end
      d = (b == hold_blk) ? hold_len : ((ack_pol == 1) ? int'($urandom_range(0, 3)) : 0);
      extra = (ack_pol == 1) && ($urandom_range(0, 1) == 1);
      repeat (d) step();
      blk_ack = 1'b1;
      if (b < BLK_LAST) push_ev(2, cyc + 2, b + 1);
      else begin
        push_ev(3, cyc + 1, 0);
        push_ev(4, cyc + 2, 0);
        if (start_in_done) push_ev(4, cyc + 3, 0);
      end
      step();
      blk_ack = extra;  // a second ack lands while blk_valid is low
      if (start_in_done && b == BLK_LAST) mb_start = 1'b1;
      step();
      blk_ack  = 1'b0;
      mb_start = 1'b0;
    end
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, l, tp;
    reset_n = 1'b0; mb_start = 1'b0; pred_mode = 2'd0; avail_left = 1'b0;
    avail_top = 1'b0; abort = 1'b0; blk_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_word(), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    step();
    chk("idle_after_reset", outs_word(), 0);

    run_mb(3, 1, 1, 0, -1, 0, -1, 0);  // Plane, both available
    run_mb(2, 0, 0, 1, -1, 0, -1, 0);  // DC, no neighbours
    run_mb(0, 0, 1, 1, 3, 5, -1, 0);   // Vertical, block 3 held 5 cycles
    run_mb(1, 1, 0, 0, -1, 0, -1, 1);  // Horizontal, immediate acks, start in DONE
    run_mb(3, 1, 1, 0, -1, 0, 2, 0);   // abort while reading group 2
    run_mb(3, 1, 1, 0, -1, 0, -1, 0);  // clean run after abort
    repeat (6) begin
      m  = int'($urandom_range(0, 3));
      l  = int'($urandom_range(0, 1));
      tp = int'($urandom_range(0, 1));
      run_mb(m, 1'(l), 1'(tp), 1, -1, 0, -1, 0);
    end
    repeat (4) step();
    chk("scoreboard_drained",
        rd_q.size() + s16_q.size() + blk_q.size() + done_q.size() + idle_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
